// File: rtl/div_16b_seq_pkg.sv
// ============================================================================
// Module  : div_16b_seq_pkg
// Brief   : Shared types and constants for the 16-bit sequential divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package div_16b_seq_pkg;

    localparam int DIV_W    = 16;
    localparam int DIV_ITER = 16;
    localparam logic [DIV_W-1:0] DZ_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic [DIV_W-1:0] twos_neg(input logic [DIV_W-1:0] v);
        return (~v) + {{(DIV_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_16b_seq_cla.sv
// ============================================================================
// Module  : div_16b_seq_cla
// Brief   : 16-bit carry-lookahead adder, 4-bit groups with a second-level
//           lookahead across groups. Used by the divider as a subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_16b_seq_cla
    import div_16b_seq_pkg::*;
(
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    input  logic             c_in,
    output logic [DIV_W-1:0] sum,
    output logic             c_out
);

    logic [DIV_W-1:0] w_g;
    logic [DIV_W-1:0] w_p;
    logic [DIV_W-1:0] w_c;
    logic [3:0]       w_gg;
    logic [3:0]       w_gp;
    logic [4:0]       w_gc;

    assign w_g = a & b;
    assign w_p = a ^ b;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_grp
            localparam int B = 4 * gi;
            assign w_c[B]   = w_gc[gi];
            assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[gi]);
            assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                            | (w_p[B+1] & w_p[B] & w_gc[gi]);
            assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                            | (w_p[B+2] & w_p[B+1] & w_g[B])
                            | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[gi]);
            assign w_gg[gi] = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                            | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                            | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
            assign w_gp[gi] = &w_p[B+3:B];
        end
    endgenerate

    // Second-level lookahead: group carries derived straight from c_in
    assign w_gc[0] = c_in;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & c_in);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & c_in);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & c_in);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & c_in);

    assign sum   = w_p ^ w_c;
    assign c_out = w_gc[4];

endmodule

`default_nettype wire

// File: rtl/div_16b_seq.sv
// ============================================================================
// Module  : div_16b_seq
// Brief   : Iterative 16-bit restoring divider, one trial subtraction per
//           clock, start/done handshake. Macro SIGNED_DIV_EN adds signed mode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_16b_seq
    import div_16b_seq_pkg::*;
#(
    parameter int N     = 16,
    parameter int CNT_W = 5
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [N-1:0]     dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     rem_q, rem_d;
    logic [N-1:0]     quo_q, quo_d;
    logic [N-1:0]     dvsr_q, dvsr_d;
    logic             dz_q, dz_d;

    logic [N-1:0]     w_a_mag;
    logic [N-1:0]     w_b_mag;
    logic [N:0]       w_shift_r;
    logic [N-1:0]     w_trial;
    logic             w_no_borrow;
    logic             w_qbit;

`ifdef SIGNED_DIV_EN
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    always_comb begin
        w_a_mag = dividend;
        w_b_mag = divisor;
        if (signed_op && dividend[N-1]) w_a_mag = twos_neg(dividend);
        if (signed_op && divisor[N-1])  w_b_mag = twos_neg(divisor);
    end
`else
    logic             w_unused_signed_op;

    assign w_unused_signed_op = signed_op;
    assign w_a_mag            = dividend;
    assign w_b_mag            = divisor;
`endif

    // Partial remainder shifted left with the next dividend bit from Q's MSB
    assign w_shift_r = {rem_q, quo_q[N-1]};

    div_16b_seq_cla u_cla (
        .a     (w_shift_r[N-1:0]),
        .b     (~dvsr_q),
        .c_in  (1'b1),
        .sum   (w_trial),
        .c_out (w_no_borrow)
    );

    // A set bit 16 means R >= 2^16 > divisor, so the subtraction must succeed
    assign w_qbit = w_shift_r[N] | w_no_borrow;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        dz_d    = dz_q;
`ifdef SIGNED_DIV_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        dz_d    = 1'b1;
                        quo_d   = DZ_QUOT;
                        rem_d   = dividend;
                        cnt_d   = '0;
`ifdef SIGNED_DIV_EN
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
`endif
                    end else begin
                        state_d = RUN;
                        dz_d    = 1'b0;
                        cnt_d   = CNT_W'(N);
                        quo_d   = w_a_mag;
                        rem_d   = '0;
                        dvsr_d  = w_b_mag;
`ifdef SIGNED_DIV_EN
                        neg_quo_d = signed_op & (dividend[N-1] ^ divisor[N-1]);
                        neg_rem_d = signed_op & dividend[N-1];
`endif
                    end
                end
            end
            RUN: begin
                quo_d = {quo_q[N-2:0], w_qbit};
                rem_d = w_qbit ? w_trial : w_shift_r[N-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            dz_q    <= dz_d;
        end
    end

`ifdef SIGNED_DIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign quotient  = (state_q == DONE && neg_quo_q) ? twos_neg(quo_q) : quo_q;
    assign remainder = (state_q == DONE && neg_rem_q) ? twos_neg(rem_q) : rem_q;
`else
    assign quotient  = quo_q;
    assign remainder = rem_q;
`endif

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign div_by_zero = dz_q;

endmodule

`default_nettype wire
